// File: rtl/dram_host_ctrl.sv
// dram_host_ctrl: host-side initiator for the small DRAM model.
// Accepts client reads and writes, drives single-cycle DRAM strobes,
// captures read data after RD_LAT cycles and returns it on rsp_valid.
// A free-running timer schedules refresh windows between commands.
module dram_host_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int RD_LAT       = 1,
  parameter int REF_INTERVAL = 64,
  parameter int REF_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_read_r,
  output logic              mem_write_r,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              mem_refresh,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_READ    = 3'd2,
    S_WAIT    = 3'd3,
    S_RESP    = 3'd4,
    S_REFRESH = 3'd5
  } state_t;

  localparam int REF_CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam int WIN_W     = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
  localparam logic [REF_CNT_W-1:0] REF_LAST  = REF_CNT_W'(REF_INTERVAL - 1);
  localparam logic [WIN_W-1:0]     WIN_LAST  = WIN_W'(REF_CYCLES - 1);
  localparam logic [3:0]           WAIT_LOAD = 4'(RD_LAT - 1);

  state_t                state_q;
  state_t                state_d;
  logic [REF_CNT_W-1:0]  ref_cnt;
  logic                  ref_pending;
  logic [3:0]            wait_cnt;
  logic [WIN_W-1:0]      win_cnt;
  logic                  accept;
  logic                  ref_expire;
  logic                  ref_enter;
  logic                  wait_last;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready.
  // req_ready depends only on registered state, so it never combinationally
  // follows req_valid; the client may hold req_valid until it sees the transfer.
  assign req_ready  = (state_q == S_IDLE) && !ref_pending;
  assign accept     = req_valid && req_ready;
  assign ref_expire = (ref_cnt == REF_LAST);
  assign ref_enter  = (state_q == S_IDLE) && ref_pending;
  assign wait_last  = (state_q == S_WAIT) && (wait_cnt == 4'd0);

  // Strobes are decoded from the registered state only, so they are glitch-free
  // and mutually exclusive by construction.
  assign mem_write_r = (state_q == S_WRITE);
  assign mem_read_r  = (state_q == S_READ);
  assign rsp_valid   = (state_q == S_RESP);
  assign mem_refresh = (state_q == S_REFRESH);
  assign state       = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: a pending refresh wins over a new request in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ref_pending)    state_d = S_REFRESH;
        else if (req_valid) state_d = req_write ? S_WRITE : S_READ;
      end
      S_WRITE:   state_d = S_IDLE;
      S_READ:    state_d = S_WAIT;
      S_WAIT:    if (wait_cnt == 4'd0) state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      S_REFRESH: if (win_cnt == '0) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Free-running refresh timer, 0..REF_INTERVAL-1; keeps counting during windows.
  always_ff @(posedge clk) begin
    if (reset)           ref_cnt <= '0;
    else if (ref_expire) ref_cnt <= '0;
    else                 ref_cnt <= ref_cnt + REF_CNT_W'(1);
  end

  // Pending flag: set on expiry (a repeat expiry merges), cleared on window entry.
  always_ff @(posedge clk) begin
    if (reset)           ref_pending <= 1'b0;
    else if (ref_expire) ref_pending <= 1'b1;
    else if (ref_enter)  ref_pending <= 1'b0;
  end

  // WAIT down-counter: loaded in READ, reaches zero on the last WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset)                                        wait_cnt <= 4'd0;
    else if (state_q == S_READ)                       wait_cnt <= WAIT_LOAD;
    else if (state_q == S_WAIT && wait_cnt != 4'd0)   wait_cnt <= wait_cnt - 4'd1;
  end

  // Refresh window down-counter: loaded on entry, window ends when it hits zero.
  always_ff @(posedge clk) begin
    if (reset)                                       win_cnt <= '0;
    else if (ref_enter)                              win_cnt <= WIN_LAST;
    else if (state_q == S_REFRESH && win_cnt != '0)  win_cnt <= win_cnt - WIN_W'(1);
  end

  // Command capture: address and write data hold until the next acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr <= '0;
      mem_data <= '0;
    end else if (accept) begin
      mem_addr <= req_addr;
      mem_data <= req_wdata;
    end
  end

  // Read data capture on the last WAIT cycle; held until the next read returns.
  always_ff @(posedge clk) begin
    if (reset)          rsp_rdata <= '0;
    else if (wait_last) rsp_rdata <= mem_read_data;
  end

endmodule
